bundler_ch_seq: RTL and testbench

- Sequential channel bundler and controller. Accepts one channel hypervector (HV) per beat over a valid/ready stream.
- Keeps a per-bit popcount across the window, then emits the bitwise majority HV.
- Replaces the flat 17-input combinational channel bundler where channel HVs arrive serially from the per-channel encoder. One shared counter bank replaces NUM_CHS parallel inputs.

---
 rtl/bundler_ch_seq.sv | 153 +++++++++++++++
 tb/tb_bundler_ch_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bundler_ch_seq.sv
// bundler_ch_seq: serial channel bundler; per-bit popcount over a window of up to NUM_CHS beats, then emits the majority HV.
// Optional tie rule: define BUNDLER_TIE_FIRST_EN to resolve ties from the first accepted HV (default: ties resolve to 0).
`default_nettype none

module bundler_ch_seq #(
  parameter  int DIMENSIONS = 4,
  parameter  int NUM_CHS    = 17,
  localparam int CNT_W      = $clog2(NUM_CHS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIMENSIONS-1:0] hv_in,
  input  logic                  hv_valid,
  input  logic                  hv_last,
  output logic                  hv_ready,
  output logic [DIMENSIONS-1:0] hvout,
  output logic                  hvout_valid,
  input  logic                  hvout_ready,
  output logic                  busy,
  output logic [CNT_W-1:0]      ch_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_EMIT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_MAX_BEATS = CNT_W'(NUM_CHS);

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt [DIMENSIONS];
  logic [CNT_W-1:0]      r_ch_count;
  logic [DIMENSIONS-1:0] r_hvout;
  logic                  r_hvout_valid;
  logic                  r_hv_ready;
  logic                  r_busy;

  logic [CNT_W-1:0]      w_cnt_nxt [DIMENSIONS];
  logic [CNT_W-1:0]      w_n;
  logic [DIMENSIONS-1:0] w_tie_bits;
  logic [DIMENSIONS-1:0] w_major;
  logic                  w_accept;
  logic                  w_close;
  logic                  w_open;

  assign hv_ready    = r_hv_ready;
  assign hvout       = r_hvout;
  assign hvout_valid = r_hvout_valid;
  assign busy        = r_busy;
  assign ch_count    = r_ch_count;

  // hv_ready is only ever high in ACCUM, so the accept qualifies the state too.
  assign w_accept = hv_valid && r_hv_ready;
  assign w_n      = r_ch_count + CNT_W'(1);
  assign w_close  = w_accept && (hv_last || (w_n == C_MAX_BEATS));
  assign w_open   = start && (r_state == S_IDLE);

`ifdef BUNDLER_TIE_FIRST_EN
  logic [DIMENSIONS-1:0] r_first;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_first <= '0;
    end else if (w_open) begin
      r_first <= '0;
    end else if (w_accept && (r_ch_count == '0)) begin
      r_first <= hv_in;
    end
  end

  // The first beat can itself be the closing beat, so bypass the register then.
  assign w_tie_bits = (r_ch_count == '0) ? hv_in : r_first;
`else
  assign w_tie_bits = '0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < DIMENSIONS; gi++) begin : g_bit
      logic [CNT_W:0] w_dbl;
      logic [CNT_W:0] w_nx;

      assign w_cnt_nxt[gi] = r_cnt[gi] + CNT_W'(hv_in[gi]);
      assign w_dbl         = {w_cnt_nxt[gi], 1'b0};
      assign w_nx          = {1'b0, w_n};
      assign w_major[gi]   = (w_dbl > w_nx)  ? 1'b1 :
                             (w_dbl == w_nx) ? w_tie_bits[gi] : 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_ch_count    <= '0;
      r_hvout       <= '0;
      r_hvout_valid <= 1'b0;
      r_hv_ready    <= 1'b0;
      r_busy        <= 1'b0;
      for (int i = 0; i < DIMENSIONS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < DIMENSIONS; i++) begin
              r_cnt[i] <= '0;
            end
            r_ch_count <= '0;
            r_hv_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_ACCUM;
          end
        end

        S_ACCUM: begin
          if (w_accept) begin
            for (int i = 0; i < DIMENSIONS; i++) begin
              r_cnt[i] <= w_cnt_nxt[i];
            end
            r_ch_count <= w_n;
            if (w_close) begin
              r_hvout       <= w_major;
              r_hv_ready    <= 1'b0;
              r_hvout_valid <= 1'b1;
              r_state       <= S_EMIT;
            end
          end
        end

        S_EMIT: begin
          if (hvout_ready) begin
            r_hvout_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end
        end

        default: begin
          r_hv_ready    <= 1'b0;
          r_hvout_valid <= 1'b0;
          r_busy        <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bundler_ch_seq.sv
// tb_bundler_ch_seq: table vectors, hand-written corner sequences and randomized windows checked against a majority model.
`default_nettype none

module tb_bundler_ch_seq;
  localparam int D  = 4;
  localparam int N  = 17;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [D-1:0]  hv_in = '0;
  logic          hv_valid = 1'b0;
  logic          hv_last = 1'b0;
  logic          hv_ready;
  logic [D-1:0]  hvout;
  logic          hvout_valid;
  logic          hvout_ready = 1'b0;
  logic          busy;
  logic [CW-1:0] ch_count;

  int total = 0;
  int bad   = 0;

  logic [D-1:0] cur  [N];
  logic [D-1:0] setA [N];
  logic [D-1:0] setB [N];

  typedef struct {
    int           n;
    logic [D-1:0] b [N];
    bit           last;
    int           bub_after;
    int           bub_len;
    logic [D-1:0] exp_hv;
    int           exp_cnt;
  } vec_t;

  vec_t tbl [4];

  always #5 clk = ~clk;

  bundler_ch_seq #(.DIMENSIONS(D), .NUM_CHS(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .hv_in      (hv_in),
    .hv_valid   (hv_valid),
    .hv_last    (hv_last),
    .hv_ready   (hv_ready),
    .hvout      (hvout),
    .hvout_valid(hvout_valid),
    .hvout_ready(hvout_ready),
    .busy       (busy),
    .ch_count   (ch_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Majority over the first n entries of cur, straight from the counting rule.
  function automatic logic [D-1:0] model(input int n);
    logic [D-1:0] r;
    int ones;
    r = '0;
    for (int i = 0; i < D; i++) begin
      ones = 0;
      for (int k = 0; k < n; k++) ones += int'(cur[k][i]);
      if (2 * ones > n) r[i] = 1'b1;
      else if (2 * ones == n) begin
`ifdef BUNDLER_TIE_FIRST_EN
        r[i] = cur[0][i];
`else
        r[i] = 1'b0;
`endif
      end
    end
    return r;
  endfunction

  task automatic open_window();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_beat(input logic [D-1:0] v, input bit last);
    int t;
    t = 0;
    while (hv_ready !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (hv_ready !== 1'b1) chk("ready_timeout", {31'd0, hv_ready}, 32'd1);
    hv_in = v; hv_valid = 1'b1; hv_last = last;
    @(negedge clk);
    hv_valid = 1'b0; hv_last = 1'b0;
  endtask

  task automatic run_window(input int n, input bit use_last, input int bub_after, input int bub_len);
    open_window();
    for (int k = 0; k < n; k++) begin
      if (k == bub_after) begin
        hv_last = 1'b1;
        repeat (bub_len) @(negedge clk);
        hv_last = 1'b0;
      end
      send_beat(cur[k], use_last && (k == n - 1));
    end
    chk("valid_next_cycle", {31'd0, hvout_valid}, 32'd1);
    chk("ready_low_emit", {31'd0, hv_ready}, 32'd0);
  endtask

  task automatic handshake(input int hold, input bit start_pulse, input logic [D-1:0] expv);
    for (int d = 0; d < hold; d++) begin
      if (start_pulse && d == 1) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("hold_valid", {31'd0, hvout_valid}, 32'd1);
      chk("hold_hv", {28'd0, hvout}, {28'd0, expv});
      chk("hold_busy", {31'd0, busy}, 32'd1);
    end
    hvout_ready = 1'b1;
    if (start_pulse) start = 1'b1;
    @(negedge clk);
    hvout_ready = 1'b0; start = 1'b0;
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_valid", {31'd0, hvout_valid}, 32'd0);
    if (start_pulse) begin
      repeat (2) @(negedge clk);
      chk("no_reopen_busy", {31'd0, busy}, 32'd0);
      chk("no_reopen_ready", {31'd0, hv_ready}, 32'd0);
    end
    chk("idle_hv_kept", {28'd0, hvout}, {28'd0, expv});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [D-1:0] e;
    int           n;
    bit           ul;
    int           ba;

    setA = '{4'h6, 4'h6, 4'h6, 4'h6, 4'h4, 4'h8, 4'h0, 4'h0, 4'h9,
             4'h1, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5};
    setB = '{4'h2, 4'h2, 4'h2, 4'h6, 4'h4, 4'h8, 4'h0, 4'h0, 4'h9,
             4'h1, 4'h4, 4'h0, 4'h0, 4'h0, 4'h5, 4'h5, 4'h5};

    tbl[0].n = N; tbl[0].b = setA; tbl[0].last = 1'b0; tbl[0].bub_after = -1; tbl[0].bub_len = 0;
    tbl[0].exp_hv = 4'b0101; tbl[0].exp_cnt = 17;
    tbl[1].n = N; tbl[1].b = setB; tbl[1].last = 1'b0; tbl[1].bub_after = -1; tbl[1].bub_len = 0;
    tbl[1].exp_hv = 4'b0000; tbl[1].exp_cnt = 17;
    for (int k = 0; k < N; k++) tbl[2].b[k] = '0;
    tbl[2].b[0] = 4'b0011; tbl[2].b[1] = 4'b0101;
    tbl[2].n = 2; tbl[2].last = 1'b1; tbl[2].bub_after = -1; tbl[2].bub_len = 0; tbl[2].exp_cnt = 2;
`ifdef BUNDLER_TIE_FIRST_EN
    tbl[2].exp_hv = 4'b0011;
`else
    tbl[2].exp_hv = 4'b0001;
`endif
    tbl[3].n = N; tbl[3].b = setA; tbl[3].last = 1'b0; tbl[3].bub_after = 6; tbl[3].bub_len = 3;
    tbl[3].exp_hv = 4'b0101; tbl[3].exp_cnt = 17;

    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hvout", {28'd0, hvout}, 32'd0);
    chk("rst_valid", {31'd0, hvout_valid}, 32'd0);
    chk("rst_ready", {31'd0, hv_ready}, 32'd0);
    chk("rst_count", {27'd0, ch_count}, 32'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      cur = tbl[i].b;
      run_window(tbl[i].n, tbl[i].last, tbl[i].bub_after, tbl[i].bub_len);
      chk("tbl_hvout", {28'd0, hvout}, {28'd0, tbl[i].exp_hv});
      chk("tbl_count", {27'd0, ch_count}, tbl[i].exp_cnt);
      handshake(i, 1'b0, tbl[i].exp_hv);
    end

    // A beat offered after auto-close must wait and never be counted.
    cur = setA;
    run_window(N, 1'b0, -1, 0);
    hv_in = 4'hF; hv_valid = 1'b1;
    @(negedge clk);
    chk("extra_ready_low", {31'd0, hv_ready}, 32'd0);
    chk("extra_count", {27'd0, ch_count}, 32'd17);
    chk("extra_hv", {28'd0, hvout}, 32'd5);
    hvout_ready = 1'b1;
    @(negedge clk);
    hvout_ready = 1'b0;
    @(negedge clk);
    chk("extra_idle_busy", {31'd0, busy}, 32'd0);
    chk("extra_idle_count", {27'd0, ch_count}, 32'd17);
    hv_valid = 1'b0;

    // Backpressure with start pulses while in EMIT.
    cur = tbl[2].b;
    run_window(2, 1'b1, -1, 0);
    chk("tie_hv", {28'd0, hvout}, {28'd0, tbl[2].exp_hv});
    chk("tie_count", {27'd0, ch_count}, 32'd2);
    handshake(5, 1'b1, tbl[2].exp_hv);

    // Reset in the middle of a window.
    cur = setA;
    open_window();
    for (int k = 0; k < 9; k++) send_beat(cur[k], 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_hvout", {28'd0, hvout}, 32'd0);
    chk("mid_rst_valid", {31'd0, hvout_valid}, 32'd0);
    chk("mid_rst_count", {27'd0, ch_count}, 32'd0);
    @(negedge clk); rst = 1'b0;
    cur = setB;
    run_window(N, 1'b0, -1, 0);
    chk("post_rst_hv", {28'd0, hvout}, 32'd0);
    chk("post_rst_count", {27'd0, ch_count}, 32'd17);
    handshake(1, 1'b0, 4'b0000);

    for (int r = 0; r < 30; r++) begin
      n = $urandom_range(1, N);
      ul = (n < N) ? 1'b1 : bit'($urandom_range(0, 1));
      for (int k = 0; k < N; k++) cur[k] = D'($urandom);
      ba = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      run_window(n, ul, ba, $urandom_range(1, 3));
      e = model(n);
      chk("rnd_hv", {28'd0, hvout}, {28'd0, e});
      chk("rnd_count", {27'd0, ch_count}, n);
      handshake($urandom_range(0, 3), bit'($urandom_range(0, 1)), e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
